layer_compositor: RTL and testbench
===================================

// Module: layer_compositor
// PURPOSE
//  N-layer pixel compositor between the object/sprite units and the VGA DAC.
//  Per pixel_tick: picks the highest-priority opaque layer, else background. Keyed colour = transparent.
//  Delays hsync/vsync to match the RGB pipeline. Latches per-frame layer-overlap (collision) flags.
//  Frame-synchronous debug modes. Parametrised successor to the fixed one-object RGB mux.
// PARAMETERS
//  N_LAYERS    4       number of sprite layers, 1..15; layer 0 = highest priority
//  RGB_W       12      colour width; multiple of 3
//  TRANSP_EN   1       1: layer pixel equal to TRANSP_KEY is treated as not drawn
//  TRANSP_KEY  12'hF0F transparent key colour (RGB_W bits)
// PORTS
//  clk           in  1               system clock
//  hard_reset_n  in  1               reset, asynchronous, active-low
//  pixel_tick    in  1               pixel enable; all pipeline/state advance only when 1
//  video_on      in  1               active display area for the current input pixel
//  frame_start   in  1               1 on the tick of the first pixel of a frame
//  hsync_in      in  1               raw hsync from vga_sync
//  vsync_in      in  1               raw vsync from vga_sync
//  mode          in  2               00 normal, 01 bg-only, 10 layer-id debug, 11 = normal
//  bg_rgb        in  RGB_W           background pixel
//  layer_on      in  N_LAYERS        per-layer pixel-on flags
//  layer_rgb     in  N_LAYERS*RGB_W  layer i colour at [i*RGB_W +: RGB_W]
//  hsync         out 1               hsync delayed to align with rgb
//  vsync         out 1               vsync delayed to align with rgb
//  rgb           out RGB_W           composited pixel to DAC
//  collision     out N_LAYERS        bit i: layer i overlapped another opaque layer last frame
//  collision_vld out 1               one-clk pulse when collision updates
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//    Reset: rgb=0, hsync=0, vsync=0, collision=0, collision_vld=0, accumulator=0, active mode=00, pipeline=0.
//  - opq[i] = layer_on[i] & ~(TRANSP_EN & layer_rgb[i]==TRANSP_KEY).
//  - Stage 1 (pixel_tick): register opq, layer colours, bg_rgb, video_on.
//    Also register the winner: lowest set index of opq; none = background.
//  - Stage 2 (pixel_tick): register rgb.
//    ~video_on gives 0. Mode 01 gives bg. Mode 10: winner i gives {3{c}} with c=(i+1) in RGB_W/3 bits, no winner gives 0.
//    Otherwise (00/11): winner colour, else bg.
//  - Latency: exactly 2 pixel_ticks input to rgb.
//    hsync/vsync pass through a 2-tick shift register, so all three outputs stay aligned.
//    With no pixel_tick, outputs hold.
//  - Active mode: loaded from mode only on pixel_tick & frame_start; never changes mid-frame.
//    Applies from the frame_start pixel onward, which reaches rgb 2 ticks later.
//  - Collision accumulate (input side, on pixel_tick):
//    hit = video_on & popcount(opq)>=2; contrib = hit ? opq : 0.
//  - Collision latch: if frame_start, collision <= acc (excludes current pixel), acc <= contrib, collision_vld=1 that clk.
//    Else acc <= acc | contrib.
//  - Single-layer overlap never sets bits. Transparent pixels never collide. Blanked pixels (video_on=0) never collide.
//  - frame_start with pixel_tick=0 is ignored.
//  - Reset mid-frame: everything clears. The first collision after reset reflects only the pixels since reset.
// TESTING
//  - Reset: hard_reset_n=0 mid-stream -> rgb=0, hsync=vsync=0, collision=0 immediately (async), held until release.
//  - Priority: N=4, layer_on=4'b0110, rgb1=12'h00F, rgb2=12'h0F0, bg=12'h123, video_on=1 -> rgb=12'h00F exactly 2 ticks later.
//  - Transparency: layer_on=4'b0011, rgb0=12'hF0F, rgb1=12'hABC -> rgb=12'hABC; add layer_on=0 -> rgb=bg; video_on=0 -> rgb=0.
//  - Sync alignment: toggle hsync_in with pixel_tick every 4 clk -> hsync edge appears with the rgb of the same pixel, 2 ticks late.
//  - Collision: frame A has pixels with opq=0011 and 0100 only; at next frame_start -> collision=0011, vld pulses 1 clk.
//    Following clean frame -> collision=0000.
//  - Mode: mode=10 set mid-frame -> no change until frame_start. Then winner 2 -> rgb=12'h333, no winner -> 12'h000.

Source files
------------

// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
// layer_compositor : N-layer priority pixel compositor with sync alignment,
// per-frame collision flags and frame-synchronous debug modes.  Rev 1.0
// ============================================================================
module layer_compositor #(
    parameter int                 N_LAYERS   = 4,
    parameter int                 RGB_W      = 12,
    parameter int                 TRANSP_EN  = 1,
    parameter logic [RGB_W-1:0]   TRANSP_KEY = 12'hF0F
) (
    input  logic                        clk,
    input  logic                        hard_reset_n,
    input  logic                        pixel_tick,
    input  logic                        video_on,
    input  logic                        frame_start,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic [1:0]                  mode,
    input  logic [RGB_W-1:0]            bg_rgb,
    input  logic [N_LAYERS-1:0]         layer_on,
    input  logic [N_LAYERS*RGB_W-1:0]   layer_rgb,
    output logic                        hsync,
    output logic                        vsync,
    output logic [RGB_W-1:0]            rgb,
    output logic [N_LAYERS-1:0]         collision,
    output logic                        collision_vld
);

    localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int CW    = RGB_W / 3;

    localparam logic [1:0] MODE_BG  = 2'b01;
    localparam logic [1:0] MODE_DBG = 2'b10;

    logic [N_LAYERS-1:0] opq;
    logic                win_valid;
    logic [IDX_W-1:0]    win_idx;
    logic [RGB_W-1:0]    win_rgb;
    logic                multi_hit;
    logic [N_LAYERS-1:0] contrib;
    logic [1:0]          mode_now;

    logic [1:0]          active_mode;
    logic [N_LAYERS-1:0] acc;

    logic                s1_video;
    logic [1:0]          s1_mode;
    logic                s1_win_valid;
    logic [IDX_W-1:0]    s1_win_idx;
    logic [RGB_W-1:0]    s1_win_rgb;
    logic [RGB_W-1:0]    s1_bg;
    logic                s1_hsync;
    logic                s1_vsync;

    logic [CW-1:0]       dbg_c;
    logic [RGB_W-1:0]    next_rgb;

    // Scan from the lowest-priority layer upward so the lowest opaque index wins.
    always_comb begin
        opq       = '0;
        win_valid = 1'b0;
        win_idx   = '0;
        win_rgb   = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            opq[i] = layer_on[i] &&
                     !((TRANSP_EN != 0) && (layer_rgb[i*RGB_W +: RGB_W] == TRANSP_KEY));
        end
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (opq[i]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
                win_rgb   = layer_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    // Clearing the lowest set bit leaves something only when two or more are set.
    assign multi_hit = |(opq & (opq - N_LAYERS'(1)));
    assign contrib   = (video_on && multi_hit) ? opq : '0;
    assign mode_now  = frame_start ? mode : active_mode;

    always_comb begin
        dbg_c    = CW'(s1_win_idx) + CW'(1);
        next_rgb = '0;
        if (!s1_video) begin
            next_rgb = '0;
        end else if (s1_mode == MODE_BG) begin
            next_rgb = s1_bg;
        end else if (s1_mode == MODE_DBG) begin
            next_rgb = s1_win_valid ? {3{dbg_c}} : '0;
        end else begin
            next_rgb = s1_win_valid ? s1_win_rgb : s1_bg;
        end
    end

    always_ff @(posedge clk or negedge hard_reset_n) begin
        if (!hard_reset_n) begin
            active_mode   <= 2'b00;
            acc           <= '0;
            collision     <= '0;
            collision_vld <= 1'b0;
            s1_video      <= 1'b0;
            s1_mode       <= 2'b00;
            s1_win_valid  <= 1'b0;
            s1_win_idx    <= '0;
            s1_win_rgb    <= '0;
            s1_bg         <= '0;
            s1_hsync      <= 1'b0;
            s1_vsync      <= 1'b0;
            rgb           <= '0;
            hsync         <= 1'b0;
            vsync         <= 1'b0;
        end else begin
            collision_vld <= 1'b0;
            if (pixel_tick) begin
                s1_video     <= video_on;
                s1_mode      <= mode_now;
                s1_win_valid <= win_valid;
                s1_win_idx   <= win_idx;
                s1_win_rgb   <= win_rgb;
                s1_bg        <= bg_rgb;
                s1_hsync     <= hsync_in;
                s1_vsync     <= vsync_in;
                rgb          <= next_rgb;
                hsync        <= s1_hsync;
                vsync        <= s1_vsync;
                if (frame_start) begin
                    active_mode   <= mode;
                    collision     <= acc;
                    acc           <= contrib;
                    collision_vld <= 1'b1;
                end else begin
                    acc <= acc | contrib;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
// tb_layer_compositor : scoreboard bench with a reference compositing model.
// Rev 1.0
// ============================================================================
module tb_layer_compositor;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    logic        clk = 1'b0;
    logic        hard_reset_n;
    logic        pixel_tick;
    logic        video_on;
    logic        frame_start;
    logic        hsync_in;
    logic        vsync_in;
    logic [1:0]  mode;
    logic [11:0] bg_rgb;
    logic [3:0]  layer_on;
    logic [47:0] layer_rgb;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic [3:0]  collision;
    logic        collision_vld;

    exp_t       exp_q[$];
    logic [3:0] col_q[$];
    exp_t       last_exp;
    int         m_active;
    logic [3:0] m_acc;
    int         n_checks = 0;
    int         n_fail   = 0;

    layer_compositor dut (
        .clk           (clk),
        .hard_reset_n  (hard_reset_n),
        .pixel_tick    (pixel_tick),
        .video_on      (video_on),
        .frame_start   (frame_start),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .mode          (mode),
        .bg_rgb        (bg_rgb),
        .layer_on      (layer_on),
        .layer_rgb     (layer_rgb),
        .hsync         (hsync),
        .vsync         (vsync),
        .rgb           (rgb),
        .collision     (collision),
        .collision_vld (collision_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pick first opaque layer, apply mode rules, fold overlaps per frame.
    task automatic model_step(input bit von, input bit fs, input bit hs, input bit vs,
                              input logic [1:0] md, input logic [11:0] bg,
                              input logic [3:0] lon, input logic [47:0] lrgb);
        int         cnt = 0;
        int         win = -1;
        int         m;
        logic [3:0] o = 4'b0;
        exp_t       e;
        for (int i = 0; i < 4; i++) begin
            o[i] = lon[i] && (lrgb[i*12 +: 12] != 12'hF0F);
            if (o[i]) begin
                cnt++;
                if (win < 0) win = i;
            end
        end
        m = fs ? int'(md) : m_active;
        if (fs) m_active = int'(md);
        if (!von)           e.rgb = 12'h000;
        else if (m == 1)    e.rgb = bg;
        else if (m == 2)    e.rgb = (win >= 0) ? {3{4'(win + 1)}} : 12'h000;
        else                e.rgb = (win >= 0) ? lrgb[win*12 +: 12] : bg;
        e.hs = hs;
        e.vs = vs;
        exp_q.push_back(e);
        if (fs) begin
            col_q.push_back(m_acc);
            m_acc = (von && cnt >= 2) ? o : 4'b0;
        end else if (von && cnt >= 2) begin
            m_acc = m_acc | o;
        end
    endtask

    task automatic issue(input bit tick, input bit von, input bit fs, input bit hs, input bit vs,
                         input logic [1:0] md, input logic [11:0] bg,
                         input logic [3:0] lon, input logic [47:0] lrgb);
        @(negedge clk);
        pixel_tick  = tick;
        video_on    = von;
        frame_start = fs;
        hsync_in    = hs;
        vsync_in    = vs;
        mode        = md;
        bg_rgb      = bg;
        layer_on    = lon;
        layer_rgb   = lrgb;
        if (tick) model_step(von, fs, hs, vs, md, bg, lon, lrgb);
    endtask

    task automatic model_reset();
        exp_q.delete();
        col_q.delete();
        exp_q.push_back('0);
        last_exp = '0;
        m_active = 0;
        m_acc    = 4'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rgb"},       32'(rgb),           32'h0);
        chk({tag, "_hsync"},     32'(hsync),         32'h0);
        chk({tag, "_vsync"},     32'(vsync),         32'h0);
        chk({tag, "_collision"}, 32'(collision),     32'h0);
        chk({tag, "_vld"},       32'(collision_vld), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        pixel_tick = 1'b0;
        #2 hard_reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        check_reset_outputs("held_rst");
        model_reset();
        hard_reset_n = 1'b1;
    endtask

    // Monitor: each ticked edge presents one pipelined pixel; idle edges must hold.
    always @(posedge clk) begin
        logic tick_s;
        exp_t e;
        tick_s = pixel_tick;
        #1;
        if (hard_reset_n) begin
            if (tick_s) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 32'(exp_q.size()), 32'h1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rgb",   32'(rgb),   32'(e.rgb));
                    chk("hsync", 32'(hsync), 32'(e.hs));
                    chk("vsync", 32'(vsync), 32'(e.vs));
                    last_exp = e;
                end
            end else begin
                chk("hold_rgb",   32'(rgb),   32'(last_exp.rgb));
                chk("hold_hsync", 32'(hsync), 32'(last_exp.hs));
            end
            if (collision_vld) begin
                if (col_q.size() == 0) begin
                    chk("unexpected_vld", 32'(collision_vld), 32'h0);
                end else begin
                    chk("collision", 32'(collision), 32'(col_q.pop_front()));
                end
            end
        end
    end

    localparam logic [47:0] PRIO_RGB  = {12'h000, 12'h0F0, 12'h00F, 12'h000};
    localparam logic [47:0] TRANS_RGB = {12'h000, 12'h000, 12'hABC, 12'hF0F};

    initial begin
        logic [47:0] r;
        logic [3:0]  lon;
        bit          hs_t;
        hard_reset_n = 1'b0;
        pixel_tick   = 1'b0;
        video_on     = 1'b0;
        frame_start  = 1'b0;
        hsync_in     = 1'b0;
        vsync_in     = 1'b0;
        mode         = 2'b00;
        bg_rgb       = '0;
        layer_on     = '0;
        layer_rgb    = '0;
        model_reset();
        #12 check_reset_outputs("init_rst");
        @(negedge clk);
        hard_reset_n = 1'b1;

        // Priority and transparency
        issue(1, 1, 1, 0, 1, 2'b00, 12'h123, 4'b0110, PRIO_RGB);
        issue(1, 1, 0, 0, 0, 2'b00, 12'h123, 4'b0011, TRANS_RGB);
        issue(1, 1, 0, 0, 0, 2'b00, 12'h123, 4'b0000, TRANS_RGB);
        issue(1, 0, 0, 0, 0, 2'b00, 12'h123, 4'b0110, PRIO_RGB);

        // Sync alignment with a tick every fourth clock
        hs_t = 1'b0;
        for (int k = 0; k < 8; k++) begin
            hs_t = ~hs_t;
            issue(1, 1, 0, hs_t, 0, 2'b00, 12'(k), 4'(k), PRIO_RGB);
            repeat (3) issue(0, 1, 0, hs_t, 0, 2'b00, 12'h000, 4'b0000, PRIO_RGB);
        end

        // Collision: frame with overlapping 0011 plus single 0100, then a clean frame
        r = {12'h444, 12'h333, 12'h222, 12'h111};
        issue(1, 1, 1, 0, 0, 2'b00, 12'h010, 4'b0011, r);
        issue(1, 1, 0, 0, 0, 2'b00, 12'h010, 4'b0100, r);
        issue(1, 1, 0, 0, 0, 2'b00, 12'h010, 4'b0011, r);
        issue(1, 0, 0, 0, 0, 2'b00, 12'h010, 4'b1100, r);
        issue(1, 1, 0, 0, 0, 2'b00, 12'h010, 4'b0101, {12'h444, 12'hF0F, 12'h222, 12'h111});
        issue(1, 1, 1, 0, 0, 2'b00, 12'h010, 4'b1000, r);
        issue(1, 1, 0, 0, 0, 2'b00, 12'h010, 4'b0010, r);
        issue(1, 1, 1, 0, 0, 2'b00, 12'h010, 4'b0000, r);

        // Debug mode requested mid-frame only takes effect at the next frame start
        issue(1, 1, 0, 0, 0, 2'b10, 12'h010, 4'b0100, r);
        issue(1, 1, 0, 0, 0, 2'b10, 12'h010, 4'b0000, r);
        issue(1, 1, 1, 0, 0, 2'b10, 12'h010, 4'b0100, r);
        issue(1, 1, 0, 0, 0, 2'b00, 12'h010, 4'b0000, r);
        issue(1, 1, 0, 0, 0, 2'b00, 12'h010, 4'b1001, r);
        issue(1, 1, 1, 0, 0, 2'b01, 12'h5A5, 4'b0001, r);
        issue(1, 1, 0, 0, 0, 2'b00, 12'h5A5, 4'b0001, r);
        issue(1, 1, 1, 0, 0, 2'b11, 12'h5A5, 4'b0010, r);
        issue(1, 1, 0, 0, 0, 2'b11, 12'h5A5, 4'b0000, r);

        // Reset in the middle of a frame, then randomized traffic
        issue(1, 1, 0, 1, 1, 2'b00, 12'h777, 4'b0011, r);
        do_reset();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 4; i++)
                r[i*12 +: 12] = ($urandom_range(0, 3) == 0) ? 12'hF0F : 12'($urandom);
            lon = 4'($urandom);
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
                  $urandom_range(0, 29) == 0, 1'($urandom), 1'($urandom),
                  2'($urandom), 12'($urandom), lon, r);
            if (k == 300) do_reset();
        end
        issue(1, 1, 1, 0, 0, 2'b00, 12'h000, 4'b0000, r);
        repeat (3) issue(0, 0, 0, 0, 0, 2'b00, 12'h000, 4'b0000, r);

        chk("pending_pixels",     32'(exp_q.size()), 32'h1);
        chk("pending_collisions", 32'(col_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
